// File: rtl/freq_measure_scheduler_pkg.sv
// Shared types and default constants for the frequency-measurement scheduler.
package freq_measure_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_GATE    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_PRESENT = 3'd5
    } state_t;

    localparam int NUM_CH_DEF        = 4;
    localparam int CNT_W_DEF         = 24;
    localparam int GATE_CYCLES_DEF   = 1000000;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int DRAIN_CYCLES_DEF  = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One shared down-counter covers every timed state, so it is sized for the longest one.
    function automatic int timer_width(input int gate, input int settle, input int drain);
        return $clog2(max3(gate, settle, drain) + 1);
    endfunction

endpackage

// File: rtl/freq_measure_scheduler_if.sv
// Result handshake between the scheduler (master) and the host (slave).
interface freq_measure_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = freq_measure_scheduler_pkg::CNT_W_DEF
);
    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_channel;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    modport master (
        output res_valid,
        output res_channel,
        output res_count,
        output res_ovf,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_channel,
        input  res_count,
        input  res_ovf,
        output res_ready
    );
endinterface

// File: rtl/freq_measure_scheduler_rr_channel_picker.sv
// Wrap-around priority pick: first enabled channel at or after the round-robin pointer.
module rr_channel_picker
    import freq_measure_scheduler_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic [NUM_CH-1:0]         i_ch_mask,
    input  logic [$clog2(NUM_CH)-1:0] i_rr_ptr,
    output logic [$clog2(NUM_CH)-1:0] o_pick,
    output logic [$clog2(NUM_CH)-1:0] o_next_ptr,
    output logic                      o_any
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W:0] N_W = (CH_W + 1)'(NUM_CH);

    logic [CH_W:0] w_idx;
    logic [CH_W:0] w_next;

    assign o_any = |i_ch_mask;

    // Scan from farthest to nearest so the nearest enabled channel is the one left standing.
    always_comb begin
        o_pick = '0;
        w_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = {1'b0, i_rr_ptr} + (CH_W + 1)'(i);
            if (w_idx >= N_W) begin
                w_idx = w_idx - N_W;
            end
            if (i_ch_mask[w_idx[CH_W-1:0]]) begin
                o_pick = w_idx[CH_W-1:0];
            end
        end
    end

    // Pointer moves one past the channel just picked, modulo the channel count.
    always_comb begin
        w_next = {1'b0, o_pick} + (CH_W + 1)'(1);
        if (w_next >= N_W) begin
            w_next = '0;
        end
        o_next_ptr = w_next[CH_W-1:0];
    end
endmodule

// File: rtl/freq_measure_scheduler.sv
// Sequences the shared frequency-measurement datapath across the chip-output channels.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | waiting for start; nothing driven to the datapath
//   ST_SETTLE  | new channel selected, mux output settling
//   ST_CLEAR   | one-cycle clear pulse to the datapath counter
//   ST_GATE    | enable window open for exactly GATE_CYCLES
//   ST_DRAIN   | window closed, let the datapath finish; capture on last cycle
//   ST_PRESENT | result offered to host, held until accepted
module freq_measure_scheduler
    import freq_measure_scheduler_pkg::*;
#(
    parameter int NUM_CH        = NUM_CH_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int DRAIN_CYCLES  = DRAIN_CYCLES_DEF
) (
    input  logic                     i_clk_sys,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_continuous,
    input  logic                     i_abort,
    input  logic [NUM_CH-1:0]        i_ch_mask,
    input  logic [NUM_CH-1:0]        i_sig_in,
    output logic                     o_sel_signal,
    output logic                     o_meas_clear,
    output logic                     o_meas_enable,
    input  logic [CNT_W-1:0]         i_meas_count,
    output logic                     o_busy,
    output logic                     o_err_nomask,
    freq_measure_scheduler_if.master res_if
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int TMR_W = timer_width(GATE_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES);

    localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_GATE   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_DRAIN  = TMR_W'(DRAIN_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_load_val;
    logic               w_timer_load;
    logic               w_timer_tc;
    logic [CH_W-1:0]    r_cur_ch;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [CH_W-1:0]    w_pick;
    logic [CH_W-1:0]    w_rr_next;
    logic               w_any;
    logic               w_take_pick;
    logic               w_capture;
    logic               r_sel_signal;
    logic               r_err_nomask;
    logic [CH_W-1:0]    r_res_channel;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_res_ovf;

    rr_channel_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .i_ch_mask  (i_ch_mask),
        .i_rr_ptr   (r_rr_ptr),
        .o_pick     (w_pick),
        .o_next_ptr (w_rr_next),
        .o_any      (w_any)
    );

    assign w_timer_tc = (r_timer == '0);
    assign w_capture  = !i_abort && (r_state == ST_DRAIN) && w_timer_tc;

    // State register.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, timer-load and channel-pick decisions; abort overrides everything.
    always_comb begin
        w_state_next     = r_state;
        w_timer_load     = 1'b0;
        w_timer_load_val = '0;
        w_take_pick      = 1'b0;
        if (i_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_any) begin
                        w_state_next     = ST_SETTLE;
                        w_take_pick      = 1'b1;
                        w_timer_load     = 1'b1;
                        w_timer_load_val = LD_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (w_timer_tc) begin
                        w_state_next = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    w_state_next     = ST_GATE;
                    w_timer_load     = 1'b1;
                    w_timer_load_val = LD_GATE;
                end
                ST_GATE: begin
                    if (w_timer_tc) begin
                        w_state_next     = ST_DRAIN;
                        w_timer_load     = 1'b1;
                        w_timer_load_val = LD_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_timer_tc) begin
                        w_state_next = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (res_if.res_ready) begin
                        if (i_continuous && w_any) begin
                            w_state_next     = ST_SETTLE;
                            w_take_pick      = 1'b1;
                            w_timer_load     = 1'b1;
                            w_timer_load_val = LD_SETTLE;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath controls and status decode straight from the registered state.
    always_comb begin
        o_meas_clear     = (r_state == ST_CLEAR);
        o_meas_enable    = (r_state == ST_GATE);
        o_busy           = (r_state != ST_IDLE);
        res_if.res_valid = (r_state == ST_PRESENT);
    end

    // Shared down-counter: loaded on entry to a timed state, holds at zero.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (w_timer_load) begin
            r_timer <= w_timer_load_val;
        end else if (!w_timer_tc) begin
            r_timer <= r_timer - TMR_W'(1);
        end
    end

    // Current channel and round-robin pointer advance only on a pick.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_cur_ch <= '0;
            r_rr_ptr <= '0;
        end else if (w_take_pick) begin
            r_cur_ch <= w_pick;
            r_rr_ptr <= w_rr_next;
        end
    end

    // Channel mux register; metastability is left to the datapath.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_sel_signal <= 1'b0;
        end else begin
            r_sel_signal <= i_sig_in[r_cur_ch];
        end
    end

    // Flag a start request that has no channel to measure.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_err_nomask <= 1'b0;
        end else begin
            r_err_nomask <= (r_state == ST_IDLE) && i_start && !i_abort && !w_any;
        end
    end

    // Result capture on the last drain cycle; held until the next capture.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_res_channel <= '0;
            r_res_count   <= '0;
            r_res_ovf     <= 1'b0;
        end else if (w_capture) begin
            r_res_channel <= r_cur_ch;
            r_res_count   <= i_meas_count;
            r_res_ovf     <= &i_meas_count;
        end
    end

    assign o_sel_signal       = r_sel_signal;
    assign o_err_nomask       = r_err_nomask;
    assign res_if.res_channel = r_res_channel;
    assign res_if.res_count   = r_res_count;
    assign res_if.res_ovf     = r_res_ovf;
endmodule

// File: tb/tb_freq_measure_scheduler.sv
// Self-checking bench: behavioural edge-counting datapath plus a result scoreboard.
module tb_freq_measure_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 24;
    localparam int GATE   = 10;
    localparam int SETTLE = 3;
    localparam int DRAIN  = 2;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic              abort = 1'b0;
    logic [NUM_CH-1:0] mask = '0;
    logic [NUM_CH-1:0] sig_in;
    logic              tog = 1'b0;
    logic              sel, clr, en, busy, err;
    logic [CNT_W-1:0]  meas_count;
    logic [CNT_W-1:0]  dp_cnt = '0;
    logic              sel_q = 1'b0;
    logic              force_ovf = 1'b0;
    bit                gate_chk_en = 1'b1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_clear = 0;
    int   n_pop = 0;
    int   run = 0;

    freq_measure_scheduler_if #(.CH_W(CH_W), .CNT_W(CNT_W)) res_if ();

    freq_measure_scheduler #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .DRAIN_CYCLES  (DRAIN)
    ) dut (
        .i_clk_sys     (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_continuous  (cont),
        .i_abort       (abort),
        .i_ch_mask     (mask),
        .i_sig_in      (sig_in),
        .o_sel_signal  (sel),
        .o_meas_clear  (clr),
        .o_meas_enable (en),
        .i_meas_count  (meas_count),
        .o_busy        (busy),
        .o_err_nomask  (err),
        .res_if        (res_if)
    );

    always #5 clk = ~clk;
    // Period of two clock cycles, flipping on falling edges.
    always #10 tog = ~tog;

    // ch0/ch2 toggle (5 rising edges per 10-cycle gate), ch1 stuck low, ch3 stuck high.
    assign sig_in = {1'b1, tog, 1'b0, tog};

    // Behavioural datapath: counts rising edges of the selected signal while enabled.
    always @(posedge clk) begin
        sel_q <= sel;
        if (clr) dp_cnt <= '0;
        else if (en && sel && !sel_q) dp_cnt <= dp_cnt + 1'b1;
    end
    assign meas_count = force_ovf ? '1 : dp_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] c, input logic o);
        exp_t e;
        e.ch = ch; e.cnt = c; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_en(input string tag, input logic lvl, input int max);
        for (int i = 0; i < max && en !== lvl; i++) @(negedge clk);
        chk(tag, en, lvl);
    endtask

    task automatic wait_valid(input string tag, input int max);
        for (int i = 0; i < max && res_if.res_valid !== 1'b1; i++) @(negedge clk);
        chk(tag, res_if.res_valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy !== 1'b0; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: clear pulses, gate length, and scoreboard pops on each transfer.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            run = 0;
        end else begin
            if (clr) n_clear++;
            if (en) begin
                run++;
            end else begin
                if (run != 0 && gate_chk_en) chk("gate_len", run, GATE);
                run = 0;
            end
            if (res_if.res_valid && res_if.res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("res_channel", res_if.res_channel, e.ch);
                    chk("res_count", res_if.res_count, e.cnt);
                    chk("res_ovf", res_if.res_ovf, e.ovf);
                end
                n_pop++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, c0, clr_at;
        bit saw_valid;
        res_if.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, en, clr, res_if.res_valid, err, sel, res_if.res_ovf}, 0);
        chk("rst_count", res_if.res_count, 0);
        chk("rst_channel", res_if.res_channel, 0);
        rst = 1'b0;

        // Single shot on channel 2.
        mask = 4'b0100; cont = 1'b0; res_if.res_ready = 1'b1;
        push(2, 5, 0);
        p0 = n_pop; c0 = n_clear; clr_at = 0;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (clr && clr_at == 0) clr_at = k;
            if (!busy) break;
        end
        chk("t1_clear_latency", clr_at, SETTLE + 1);
        chk("t1_idle", busy, 0);
        chk("t1_results", n_pop - p0, 1);
        chk("t1_clears", n_clear - c0, 1);

        // Continuous round robin over mask 1011 from a fresh pointer.
        do_reset();
        mask = 4'b1011; cont = 1'b1;
        push(0, 5, 0); push(1, 0, 0); push(3, 0, 0); push(0, 5, 0); push(1, 0, 0);
        p0 = n_pop; c0 = n_clear;
        pulse_start();
        for (int i = 0; i < 200 && (n_pop - p0) < 4; i++) @(negedge clk);
        @(negedge clk);
        cont = 1'b0;
        wait_idle("t2_idle", 100);
        chk("t2_results", n_pop - p0, 5);
        chk("t2_clears", n_clear - c0, 5);

        // Backpressure: pointer now at 2, so channel 3 then channel 0.
        cont = 1'b1; res_if.res_ready = 1'b0;
        push(3, 0, 0); push(0, 5, 0);
        p0 = n_pop; c0 = n_clear;
        pulse_start();
        wait_valid("t3_valid", 50);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_valid_hold", res_if.res_valid, 1);
            chk("t3_gate_off", en, 0);
            chk("t3_data_hold", {res_if.res_ovf, res_if.res_count, res_if.res_channel},
                {1'b0, 24'd0, 2'd3});
        end
        res_if.res_ready = 1'b1;
        @(negedge clk);
        chk("t3_next_settle", {busy, res_if.res_valid, en, clr}, 4'b1000);
        cont = 1'b0;
        wait_idle("t3_idle", 50);
        chk("t3_results", n_pop - p0, 2);
        chk("t3_clears", n_clear - c0, 2);

        // Abort at gate cycle 5; pointer at 1 so channel 2 is picked.
        mask = 4'b0100; gate_chk_en = 1'b0;
        p0 = n_pop;
        pulse_start();
        wait_en("t4_gate_open", 1, 30);
        repeat (4) @(negedge clk);
        chk("t4_gate_c5", en, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_after_abort", {busy, en, clr, res_if.res_valid}, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (res_if.res_valid) saw_valid = 1'b1;
        end
        chk("t4_no_valid", saw_valid, 0);
        chk("t4_no_result", n_pop - p0, 0);
        gate_chk_en = 1'b1;
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("t4_abort_wins", {busy, err}, 0);

        // Empty mask error pulse.
        mask = 4'b0000;
        pulse_start();
        chk("t5_err_pulse", {err, busy}, 2'b10);
        @(negedge clk);
        chk("t5_err_drop", {err, busy}, 2'b00);

        // Saturated count sets overflow; pointer at 3 so channel 0.
        mask = 4'b0001; force_ovf = 1'b1;
        push(0, 24'hFFFFFF, 1);
        p0 = n_pop;
        pulse_start();
        wait_idle("t5_idle", 60);
        force_ovf = 1'b0;
        chk("t5_results", n_pop - p0, 1);

        // Reset during DRAIN.
        mask = 4'b0010;
        pulse_start();
        wait_en("t6_gate_open", 1, 30);
        wait_en("t6_gate_close", 0, 20);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_drain_rst", {busy, en, clr, res_if.res_valid, err, sel, res_if.res_ovf}, 0);
        chk("t6_drain_rst_cnt", res_if.res_count, 0);
        rst = 1'b0;

        // Reset during PRESENT with a non-zero result pending.
        mask = 4'b0100; res_if.res_ready = 1'b0;
        pulse_start();
        wait_valid("t6_present", 40);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_present_rst", {busy, en, clr, res_if.res_valid, err, sel, res_if.res_ovf}, 0);
        chk("t6_present_rst_res", {res_if.res_count, res_if.res_channel}, 0);
        rst = 1'b0;
        res_if.res_ready = 1'b1;

        // Fresh start after reset picks channel 0 first.
        mask = 4'b1111;
        push(0, 5, 0);
        p0 = n_pop;
        pulse_start();
        wait_idle("t6_fresh_idle", 60);
        chk("t6_fresh_results", n_pop - p0, 1);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
